// File: rtl/fetch_sequencer_if.sv
// Instruction memory read bus between fetch_sequencer (master) and instruction memory (slave).
// Handshake: the master holds imem_req high with imem_addr stable until a cycle with imem_ack; a word transfers on every rising clk edge where imem_req && imem_ack, and ack without req carries nothing.
interface fetch_sequencer_if #(
    parameter int PC_W   = 8,
    parameter int INST_W = 16
);
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_ack;
    logic [INST_W-1:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_sequencer.sv
// Program counter owner: fetches instruction words over the imem bus, holds them in the IR for
// decode, commits pc_next on exec_done, and parks in HALT on op_code 0 until a resume pulse.
module fetch_sequencer #(
    parameter int              PC_W     = 8,
    parameter int              INST_W   = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    fetch_sequencer_if.master imem,
    output logic [PC_W-1:0]   pc_now,
    output logic [3:0]        op_code,
    output logic [PC_W-1:0]   inst_addr,
    output logic [PC_W-1:0]   next_addr,
    output logic              inst_valid,
    input  logic [PC_W-1:0]   pc_next,
    input  logic              exec_done,
    input  logic              resume,
    output logic              halted,
    output logic [15:0]       instr_count,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t            state;
    logic [INST_W-1:0] ir;
    logic [15:0]       count_q;
    logic              req_q;
    logic              unused_ir_bits;

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_now;
    assign op_code        = ir[INST_W-1 -: 4];
    assign inst_addr      = ir[PC_W-1:0];
    assign next_addr      = ir[PC_W-1:0];
    assign instr_count    = count_q;
    assign dbg_state      = state;
    assign unused_ir_bits = ^ir[INST_W-5:PC_W];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            pc_now     <= RESET_PC;
            ir         <= '0;
            count_q    <= '0;
            req_q      <= 1'b0;
            inst_valid <= 1'b0;
            halted     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                    req_q <= 1'b1;
                end
                FETCH: begin
                    if (imem.imem_ack) begin
                        ir         <= imem.imem_rdata;
                        req_q      <= 1'b0;
                        inst_valid <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    // exec_done outranks resume here; resume only matters in HALT
                    if (exec_done) begin
                        pc_now     <= pc_next;
                        inst_valid <= 1'b0;
                        if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
                        if (op_code == 4'b0000) begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end else begin
                            req_q <= 1'b1;
                            state <= FETCH;
                        end
                    end
                end
                HALT: begin
                    if (resume) begin
                        pc_now <= pc_now + PC_W'(1);
                        halted <= 1'b0;
                        req_q  <= 1'b1;
                        state  <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Holds the architectural program counter and fetches instruction words from instruction memory over a req/ack handshake.
- Latches each fetched word into an instruction register and splits it into op_code, inst_addr and next_addr for the PC control logic and decode.
- Commits the PC control's pc_next once the execute side signals completion.
- Sits between instruction memory and the PC control/decode stage.

Parameters:
PC_W, 8, program counter and address width
INST_W, 16, instruction word width; op_code = [INST_W-1:INST_W-4], address field = [PC_W-1:0]
RESET_PC, 8'h00, PC value loaded on reset

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
imem_req  output  1  instruction read request
imem_addr  output  PC_W  read address, equal to pc_now
imem_ack  input  1  read data valid this cycle; sampled only while imem_req=1
imem_rdata  input  INST_W  instruction word, valid with imem_ack
pc_now  output  PC_W  current PC (registered)
op_code  output  4  IR[15:12]
inst_addr  output  PC_W  IR[7:0], jump target
next_addr  output  PC_W  IR[7:0], branch offset
inst_valid  output  1  IR holds a valid instruction awaiting execution
pc_next  input  PC_W  next PC from PC control
exec_done  input  1  execute finished with the current instruction; commit pc_next
resume  input  1  single-cycle pulse that leaves HALT
halted  output  1  sequencer is in HALT
instr_count  output  16  retired instruction count, saturating at 16'hFFFF

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values:
  - state=IDLE, pc_now=RESET_PC, IR=0.
  - imem_req=0, inst_valid=0, halted=0, instr_count=0.
  - op_code, inst_addr and next_addr are therefore all 0.
- States: IDLE, FETCH, EXEC, HALT.
- IDLE:
  - Entered only via reset.
  - First clock edge after reset_n deasserts moves to FETCH.
- FETCH:
  - imem_req=1; imem_addr=pc_now, held stable until ack.
  - On a cycle with imem_ack=1: IR <= imem_rdata, move to EXEC. inst_valid=1 from the next cycle.
  - Latency is 1 cycle from ack to inst_valid.
  - Ack in the same cycle req first rises is legal, giving a minimum 2-cycle fetch (req cycle, then EXEC).
- EXEC:
  - imem_req=0, inst_valid=1; IR fields are stable for the whole state.
  - On exec_done=1: pc_now <= pc_next, instr_count += 1 (saturating), inst_valid <= 0.
  - If op_code==4'b0000, go to HALT. Otherwise go to FETCH.
  - exec_done is ignored in every other state.
- HALT:
  - halted=1, imem_req=0, inst_valid=0; pc_now holds the committed value (PC control returns pc_now for halt).
  - On resume=1: pc_now <= pc_now + 1 (mod 2^PC_W), halted <= 0, go to FETCH.
  - resume outside HALT is ignored.
- Arithmetic:
  - All PC values are PC_W bits and wrap modulo 2^PC_W; 8'hFF + 1 = 8'h00.
  - The sequencer performs no target arithmetic beyond the resume increment.
- imem_ack while imem_req=0 is ignored; IR is unchanged.
- Reset mid-operation:
  - imem_req, inst_valid and halted drop immediately (asynchronously).
  - Any outstanding fetch is abandoned; memory must tolerate a dropped request.
- Simultaneous events:
  - exec_done and resume in the same EXEC cycle: exec_done wins, resume is dropped.
  - imem_ack and reset_n=0: reset wins.
- instr_count counts halt instructions when they retire; it holds at 16'hFFFF once reached.

Test Plan:
- Reset/start: reset_n low, then release; imem_ack tied 1, rdata=16'h1000 -> cycle 1 imem_req=1, imem_addr=8'h00; next cycle inst_valid=1, op_code=4'h1.
- Sequential retire: pc_next driven as pc_now+1, exec_done=1 in every EXEC cycle -> pc_now sequence 00,01,02; instr_count=3 after three retirements.
- Jump with slow memory: IR=16'h5040, ack delayed 3 cycles -> imem_req held 3 cycles with imem_addr stable; inst_addr=8'h40; pc_next=8'h40 with exec_done -> next imem_addr=8'h40.
- Halt/resume: IR=16'h0000 at pc=8'h07, exec_done with pc_next=8'h07 -> halted=1, imem_req=0; resume pulse -> halted=0, imem_addr=8'h08. A resume pulse sent before the halt has no effect.
- Wrap and abort:
  - Commit pc_next=8'hFF, then halt and resume -> pc_now=8'h00.
  - Assert reset_n low during FETCH with ack pending -> imem_req falls the same cycle; pc_now=8'h00 and instr_count=0.
- Saturation and precedence:
  - Preload instr_count to 16'hFFFE and retire 3 instructions -> count ends at 16'hFFFF.
  - exec_done+resume together in EXEC -> FETCH with pc_now=pc_next, no increment.
